// File: rtl/float_e4m3_pkg.sv
// Format constants and shared types for the E4M3 arithmetic stages
// (1 sign, 4 exponent bits with bias 7, 3 mantissa bits).
package float_e4m3_pkg;

    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int BIAS  = 7;

    localparam logic [6:0] E4M3_MAX_MAG = 7'b1111110;
    localparam logic [7:0] E4M3_NAN     = 8'h7F;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_MUL0,
        ST_MUL1,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/e4m3_unpack.sv
// Combinational decode of one E4M3 operand into sign, exponent, mantissa with
// hidden bit, and zero/NaN flags. Subnormals are flushed to zero.
module e4m3_unpack
    import float_e4m3_pkg::*;
(
    input  logic [7:0]       value,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   mant,
    output logic             is_zero,
    output logic             is_nan
);

    assign sign    = value[7];
    assign exp     = value[6:3];
    assign mant    = {1'b1, value[2:0]};
    assign is_zero = (value[6:3] == '0);
    assign is_nan  = (value[6:0] == 7'h7F);

endmodule

// File: rtl/float_multiplier_e4m3.sv
// Multi-cycle E4M3 multiplier: one product per reset release, computed with a
// two-step radix-4 mantissa multiply, truncated and saturated to +/-448.
module float_multiplier_e4m3
    import float_e4m3_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       is_output_valid
);

    logic             a_sign, b_sign, a_zero, b_zero, a_nan, b_nan;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W:0]   a_mant, b_mant;

    e4m3_unpack u_unpack_a (
        .value   (a),
        .sign    (a_sign),
        .exp     (a_exp),
        .mant    (a_mant),
        .is_zero (a_zero),
        .is_nan  (a_nan)
    );

    e4m3_unpack u_unpack_b (
        .value   (b),
        .sign    (b_sign),
        .exp     (b_exp),
        .mant    (b_mant),
        .is_zero (b_zero),
        .is_nan  (b_nan)
    );

    state_t             state;
    logic               sign_r, nan_r, zero_r;
    logic signed [5:0]  exp_r;
    logic [MAN_W:0]     ma_r, mb_r;
    logic [7:0]         acc;

    logic signed [5:0]  exp_sum;
    logic [1:0]         slice;
    logic [7:0]         partial;
    logic signed [5:0]  exp_norm;
    logic [2:0]         man_norm;
    logic [7:0]         y_next;

    assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(6'(BIAS));

    // Low radix-4 digit of mb in MUL0, high digit in MUL1.
    assign slice   = (state == ST_MUL0) ? mb_r[1:0] : mb_r[3:2];
    assign partial = {4'b0000, ma_r} * {6'b000000, slice};

    always_comb begin
        exp_norm = acc[7] ? exp_r + 6'sd1 : exp_r;
        man_norm = acc[7] ? acc[6:4] : acc[5:3];
        if (nan_r) begin
            y_next = E4M3_NAN;
        end else if (zero_r || exp_norm <= 6'sd0) begin
            y_next = {sign_r, 7'b0000000};
        end else if (exp_norm > 6'sd15 || (exp_norm == 6'sd15 && man_norm == 3'b111)) begin
            // S.1111.111 is NaN, so the largest finite magnitude is 448.
            y_next = {sign_r, E4M3_MAX_MAG};
        end else begin
            y_next = {sign_r, exp_norm[3:0], man_norm};
        end
    end

    // NOTE: state registers use non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_LOAD;
            y               <= 8'h00;
            is_output_valid <= 1'b0;
            sign_r          <= 1'b0;
            nan_r           <= 1'b0;
            zero_r          <= 1'b0;
            exp_r           <= '0;
            ma_r            <= '0;
            mb_r            <= '0;
            acc             <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    sign_r <= a_sign ^ b_sign;
                    nan_r  <= a_nan | b_nan;
                    zero_r <= a_zero | b_zero;
                    exp_r  <= exp_sum;
                    ma_r   <= a_mant;
                    mb_r   <= b_mant;
                    acc    <= '0;
                    state  <= ST_MUL0;
                end
                ST_MUL0: begin
                    acc   <= acc + partial;
                    state <= ST_MUL1;
                end
                ST_MUL1: begin
                    acc   <= acc + (partial << 2);
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    y               <= y_next;
                    is_output_valid <= 1'b1;
                    state           <= ST_DONE;
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_multiplier_e4m3.sv
// Directed-vector bench for float_multiplier_e4m3 with a queue-based
// scoreboard checked by an independent monitor process.
module tb_float_multiplier_e4m3;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       is_output_valid;

    float_multiplier_e4m3 dut (
        .clock           (clock),
        .reset           (reset),
        .a               (a),
        .b               (b),
        .y               (y),
        .is_output_valid (is_output_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] value;
    } expect_t;

    expect_t expected_q[$];
    int      checks_total  = 0;
    int      checks_passed = 0;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
        checks_total++;
        if (actual === required) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %02h, expected %02h", name, actual, required);
        end
    endtask

    // Monitor: compares y against the scoreboard on each rising of valid.
    logic valid_seen = 1'b0;
    always @(negedge clock) begin
        if (is_output_valid && !valid_seen) begin
            valid_seen = 1'b1;
            if (expected_q.size() == 0) begin
                check("unexpected_valid", y, 8'hxx);
            end else begin
                expect_t e;
                e = expected_q.pop_front();
                check(e.name, y, e.value);
            end
        end
        if (!is_output_valid) valid_seen = 1'b0;
    end

    // One full operation: release reset, watch the fixed latency, confirm
    // the result holds while operands change, then reassert reset.
    task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [7:0] ey);
        expect_t e;
        a = ta;
        b = tb;
        @(posedge clock);
        #1;
        reset = 1'b0;
        e.name  = name;
        e.value = ey;
        expected_q.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock);
            #1;
            if (i == 1) begin
                a = ~ta;
                b = 8'h5A;
            end
            if (i == 3) check({name, "_valid_low_edge3"}, {7'b0, is_output_valid}, 8'd0);
            if (i == 4) check({name, "_valid_high_edge4"}, {7'b0, is_output_valid}, 8'd1);
        end
        a = 8'h3C;
        b = 8'hC4;
        repeat (2) @(posedge clock);
        #1;
        check({name, "_y_hold"}, y, ey);
        check({name, "_valid_hold"}, {7'b0, is_output_valid}, 8'd1);
        reset = 1'b1;
        #1;
        check({name, "_reset_y"}, y, 8'h00);
        check({name, "_reset_valid"}, {7'b0, is_output_valid}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
        #1;
        check("reset_y", y, 8'h00);
        check("reset_valid", {7'b0, is_output_valid}, 8'd0);

        run_op("two_sq",      8'h40, 8'h40, 8'h48);
        run_op("onep5_sq",    8'h3C, 8'h3C, 8'h41);
        run_op("trunc",       8'h39, 8'h39, 8'h3A);
        run_op("neg",         8'hC0, 8'h44, 8'hCC);
        run_op("max_mant",    8'h3F, 8'h3F, 8'h46);
        run_op("overflow",    8'h78, 8'h48, 8'h7E);
        run_op("e15_m7_sat",  8'h7B, 8'h3B, 8'h7E);
        run_op("e15_ok",      8'h78, 8'h38, 8'h78);
        run_op("underflow",   8'h10, 8'h10, 8'h00);
        run_op("e0_zero",     8'h20, 8'h18, 8'h00);
        run_op("e1_min",      8'h20, 8'h20, 8'h08);
        run_op("norm_to_e1",  8'h1C, 8'h24, 8'h09);
        run_op("nan_zero",    8'hFF, 8'h00, 8'h7F);
        run_op("nan_pos",     8'h40, 8'h7F, 8'h7F);
        run_op("neg_zero",    8'h80, 8'h48, 8'h80);

        // Abandon an operation while MUL1 is executing.
        a = 8'h3C;
        b = 8'h3C;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_y", y, 8'h00);
        check("abort_valid", {7'b0, is_output_valid}, 8'd0);
        @(posedge clock);
        #1;
        check("abort_still_idle", {7'b0, is_output_valid}, 8'd0);

        run_op("after_abort", 8'h48, 8'h48, 8'h58);

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", 8'(expected_q.size()), 8'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/float_multiplier_e4m3.md
# float_multiplier_e4m3

Multi-cycle multiplier for 8-bit E4M3 floating-point operands (1 sign, 4 exponent bits with bias 7, 3 mantissa bits). It is the stage directly upstream of `float_adder_e4m3`: its `y`/`is_output_valid` pair feeds the adder's operand inputs to form multiply-accumulate paths. It uses the same start-on-reset-release protocol as the adder, so one controller can sequence both stages.

## Interface
- No parameters. Format constants come from the shared package.
- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high. While high, the block is held idle. Its falling edge starts one multiplication.
- `a`  input  8  E4M3 operand; must be stable from reset release through the LOAD edge.
- `b`  input  8  E4M3 operand; same stability rule as `a`.
- `y`  output  8  E4M3 product, registered.
- `is_output_valid`  output  1  high when `y` holds the finished product.

## Operation
- Decode per operand: sign `s`, exponent `e`, mantissa `m`.
  - Mantissa with hidden bit: `M = {1, m}`, 4 bits.
  - `e == 0` (zero or subnormal) is treated as zero (flush-to-zero).
  - `S_1111_111` is NaN.
- Specials, in priority order:
  - Either input NaN -> `y = 8'h7F`.
  - Else either input zero -> `y = {sa^sb, 7'b0}`.
- Normal path:
  - Sign: `s = sa ^ sb`.
  - Exponent: `E = ea + eb - 7`, signed, 6 bits or wider.
  - Mantissa: 4x4 -> 8-bit product `P` in Q2.6, range 64..225.
  - The product is computed radix-4: two iterations, each adding `Ma * 2-bit slice of Mb`, shifted.
- Normalise:
  - If `P[7]` is set: `E = E + 1`, mantissa = `P[6:4]`.
  - Otherwise: mantissa = `P[5:3]`.
- Rounding: truncate (round toward zero). There is no sticky or guard logic.
- Range:
  - `E <= 0` -> `{s, 7'b0}`.
  - `E > 15`, or (`E == 15` and mantissa `== 3'b111`) -> saturate to `{s, 7'b1111110}` (±448).
  - Otherwise -> `{s, E[3:0], mantissa}`.
- FSM:
  - LOAD: capture and decode operands, compute the special flags and `E`, clear the accumulator.
  - MUL0: first radix-4 step.
  - MUL1: second radix-4 step.
  - NORM: normalise, apply range rules and specials, register `y`, set valid.
  - DONE: hold.
- Transitions: LOAD -> MUL0 -> MUL1 -> NORM -> DONE. DONE holds until reset.
- Specials still pass through MUL0/MUL1, so latency is fixed.

## Timing
- Reset values, applied asynchronously and immediately:
  - `y = 8'h00`
  - `is_output_valid = 0`
  - state = LOAD
  - accumulator, exponent and flags = 0
- Edge numbering: edge 1 is the first rising edge with `reset` low. Edges 1–4 execute LOAD, MUL0, MUL1 and NORM.
- `is_output_valid` rises right after edge 4. Fixed latency is 4 cycles; a bench check at 5 edges passes.
- After valid: `y` and `is_output_valid` stay constant while `reset` is low, including if `a`/`b` change.
- `a`/`b` changing after edge 1 has no effect on the result.
- Reset reasserted mid-operation (any state): outputs clear at once and the operation is abandoned. The next release restarts at LOAD.
- Reset asserted on a clock edge: reset wins.
- A 1-cycle reset pulse is enough to start a new operation.

## Structure
- Package `float_e4m3_pkg`, shared with `float_adder_e4m3`, holds:
  - `EXP_W = 4`, `MAN_W = 3`, `BIAS = 7`
  - `E4M3_MAX_MAG = 7'b1111110`, `E4M3_NAN = 8'h7F`
  - the FSM state enum
- One natural sub-module, `e4m3_unpack`: combinational decode of one operand into `{sign, exp, mant_with_hidden, is_zero, is_nan}`. It is instantiated twice here and is reusable by the adder.
- Everything else lives in `float_multiplier_e4m3`: FSM, radix-4 accumulator, normalise/pack.

## Test plan
- `a = 8'h40` (2), `b = 8'h40` -> `y = 8'h48` (4), valid after edge 4.
- `a = 8'h3C` (1.5), `b = 8'h3C` -> `y = 8'h41` (2.25); `a = 8'h39`, `b = 8'h39` (1.125²) -> `y = 8'h3A` (truncated).
- `a = 8'hC0` (-2), `b = 8'h44` (3) -> `y = 8'hCC` (-6).
- Overflow and underflow:
  - `a = 8'h78` (256), `b = 8'h48` -> `y = 8'h7E` (saturate).
  - `a = 8'h10`, `b = 8'h10` (2^-10) -> `y = 8'h00`.
- Specials:
  - `a = 8'hFF`, `b = 8'h00` -> `y = 8'h7F`.
  - `a = 8'h80`, `b = 8'h48` -> `y = 8'h80`.
- Reset mid-operation: reassert `reset` during MUL1 -> `y = 8'h00`, valid low at once. After release with new operands `8'h48 * 8'h48` -> `y = 8'h58`, valid after edge 4.
